// File: rtl/rpn_op_engine.sv
// RPN operator stage: pops TOS/NOS, writes NOS op TOS back, drops SP by one.
// Define RPN_MUL_EN to build the multiplier for opcode 101.
module rpn_op_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  output logic              op_ready,
  output logic              busy,
  input  logic [ADDR_W-1:0] sp_in,
  output logic [ADDR_W-1:0] sp_out,
  output logic              sp_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              carry,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    IDLE, RD_TOS, RD_NOS, CAP_NOS,
    EXEC, WRITE, UPD_SP, ERR
  } state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] sp_q;
  logic [DATA_W-1:0] tos;
  logic [DATA_W-1:0] nos;
  logic              bad_op;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   dif;

`ifdef RPN_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, nos}
              * {{DATA_W{1'b0}}, tos};
  assign bad_op = op_code[2] & op_code[1];
`else
  assign bad_op = op_code[2]
                & (op_code[1] | op_code[0]);
`endif

  assign sum = {1'b0, nos} + {1'b0, tos};
  assign dif = {1'b0, nos} - {1'b0, tos};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      3'b000: {alu_c, alu_res} = sum;
      3'b001: {alu_c, alu_res} = dif;
      3'b010: alu_res = nos & tos;
      3'b011: alu_res = nos | tos;
      3'b100: alu_res = nos ^ tos;
`ifdef RPN_MUL_EN
      3'b101: begin
        alu_res = prod[DATA_W-1:0];
        alu_c   = |prod[2*DATA_W-1:DATA_W];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= IDLE;
      op_q         <= '0;
      sp_q         <= '0;
      tos          <= '0;
      nos          <= '0;
      op_ready     <= 1'b1;
      busy         <= 1'b0;
      sp_out       <= '0;
      sp_wr        <= 1'b0;
      mem_addr     <= '0;
      mem_wr       <= 1'b0;
      mem_wdata    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      carry        <= 1'b0;
      err          <= 1'b0;
      err_code     <= 2'b00;
    end else begin
      // strobes and address/SP buses default low every cycle
      sp_out       <= '0;
      sp_wr        <= 1'b0;
      mem_addr     <= '0;
      mem_wr       <= 1'b0;
      mem_wdata    <= '0;
      result_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (op_valid) begin
            op_q     <= op_code;
            sp_q     <= sp_in;
            err      <= 1'b0;
            op_ready <= 1'b0;
            busy     <= 1'b1;
            if (sp_in < ADDR_W'(2)) begin
              err_code <= 2'b01;
              state    <= ERR;
            end else if (bad_op) begin
              err_code <= 2'b10;
              state    <= ERR;
            end else begin
              err_code <= 2'b00;
              mem_addr <= sp_in - ADDR_W'(1);
              state    <= RD_TOS;
            end
          end
        end
        ERR: begin
          err      <= 1'b1;
          op_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        RD_TOS: begin
          mem_addr <= sp_q - ADDR_W'(2);
          state    <= RD_NOS;
        end
        RD_NOS: begin
          tos   <= mem_rdata;
          state <= CAP_NOS;
        end
        CAP_NOS: begin
          nos   <= mem_rdata;
          state <= EXEC;
        end
        EXEC: begin
          result    <= alu_res;
          carry     <= alu_c;
          mem_addr  <= sp_q - ADDR_W'(2);
          mem_wdata <= alu_res;
          mem_wr    <= 1'b1;
          state     <= WRITE;
        end
        WRITE: begin
          sp_out       <= sp_q - ADDR_W'(1);
          sp_wr        <= 1'b1;
          result_valid <= 1'b1;
          state        <= UPD_SP;
        end
        UPD_SP: begin
          op_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_op_engine.sv
// Bench for rpn_op_engine: table vectors, random ops vs. reference model,
// and a mid-operation reset sequence.
module tb_rpn_op_engine;

`ifdef RPN_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N;
  logic       op_valid;
  logic [2:0] op_code;
  logic       op_ready;
  logic       busy;
  logic [7:0] sp_in;
  logic [7:0] sp_out;
  logic       sp_wr;
  logic [7:0] mem_addr;
  logic       mem_wr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] result;
  logic       result_valid;
  logic       carry;
  logic       err;
  logic [1:0] err_code;

  logic [7:0] mem [256];

  int n_vec  = 0;
  int n_miss = 0;
  int hold_r = 0;
  int hold_c = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  rpn_op_engine dut (
    .CLOCK_50     (CLOCK_50),
    .RESET_N      (RESET_N),
    .op_valid     (op_valid),
    .op_code      (op_code),
    .op_ready     (op_ready),
    .busy         (busy),
    .sp_in        (sp_in),
    .sp_out       (sp_out),
    .sp_wr        (sp_wr),
    .mem_addr     (mem_addr),
    .mem_wr       (mem_wr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .result       (result),
    .result_valid (result_valid),
    .carry        (carry),
    .err          (err),
    .err_code     (err_code)
  );

  // synchronous-read stack RAM
  always @(posedge CLOCK_50) begin
    mem_rdata <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] = mem_wdata;
  end

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h",
               n, act, exp);
    end
  endtask

  function automatic void model(
    input  logic [2:0] op,
    input  int         sp, a, b,
    output int         r, c, ec);
    r = 0; c = 0; ec = 0;
    if (sp < 2) ec = 1;
    else if (op > 5 || (op == 5 && !MUL_ON)) ec = 2;
    else begin
      case (op)
        0: begin r = a + b; c = int'(r > 255); end
        1: begin r = a - b; c = int'(a < b); end
        2: r = a & b;
        3: r = a | b;
        4: r = a ^ b;
        default: begin r = a * b; c = int'(r > 255); end
      endcase
      r = r & 255;
    end
  endfunction

  task automatic apply(input string t,
                       input logic [2:0] op,
                       input logic [7:0] sp,
                       input int xr, xc, xec);
    int lo, hi, rdy, wn, wc, wa, wd;
    int sn, sc, so, rvc;
    bit bz;
    lo = int'(sp) - 2;
    hi = int'(sp) - 1;
    rdy = 0; wn = 0; wc = 0; wa = 0; wd = 0;
    sn = 0; sc = 0; so = 0; rvc = 0; bz = 0;
    @(negedge CLOCK_50);
    op_valid = 1'b1;
    op_code  = op;
    sp_in    = sp;
    @(posedge CLOCK_50);
    #1;
    op_valid = 1'b0;
    sp_in    = 8'($urandom);
    op_code  = 3'($urandom);
    for (int c = 1; c <= 12 && rdy == 0; c++) begin
      @(negedge CLOCK_50);
      if (mem_wr) begin
        wn++; wc = c;
        wa = int'(mem_addr); wd = int'(mem_wdata);
      end
      if (sp_wr) begin
        sn++; sc = c; so = int'(sp_out);
      end
      if (result_valid) rvc = c;
      if (busy === op_ready) bz = 1'b1;
      if (op_ready) begin
        rdy = c;
        op_valid = 1'b0;
      end else begin
        op_valid = 1'($urandom_range(0, 1));
      end
    end
    op_valid = 1'b0;
    chk({t, ".ready_cyc"}, rdy, (xec != 0) ? 2 : 7);
    chk({t, ".busy"}, 32'(bz), 0);
    chk({t, ".wr_cnt"}, wn, (xec != 0) ? 0 : 1);
    chk({t, ".spwr_cnt"}, sn, (xec != 0) ? 0 : 1);
    chk({t, ".err"}, 32'(err), 32'(xec != 0));
    chk({t, ".err_code"}, 32'(err_code), xec);
    if (xec == 0) begin
      chk({t, ".wr_cyc"}, wc, 5);
      chk({t, ".wr_addr"}, wa, lo);
      chk({t, ".wr_data"}, wd, xr);
      chk({t, ".spwr_cyc"}, sc, 6);
      chk({t, ".sp_out"}, so, hi);
      chk({t, ".rv_cyc"}, rvc, 6);
      chk({t, ".mem_nos"}, 32'(mem[lo]), xr);
      hold_r = xr;
      hold_c = xc;
    end
    chk({t, ".result"}, 32'(result), hold_r);
    chk({t, ".carry"}, 32'(carry), hold_c);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] sp;
    logic [7:0] a;
    logic [7:0] b;
    int         r;
    int         c;
    int         ec;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int r, c, ec, a, b;
    logic [2:0] op;
    logic [7:0] sp;
    logic [7:0] keep;
    tbl.push_back('{3'd0, 8'd2, 8'd7, 8'd5, 12, 0, 0});
    tbl.push_back('{3'd1, 8'd2, 8'd7, 8'd5, 2, 0, 0});
    tbl.push_back('{3'd1, 8'd2, 8'd5, 8'd7, 254, 1, 0});
    tbl.push_back('{3'd0, 8'd2, 8'd200, 8'd100, 44, 1, 0});
    tbl.push_back('{3'd0, 8'd1, 8'd0, 8'd9, 0, 0, 1});
    tbl.push_back('{3'd6, 8'd2, 8'd1, 8'd2, 0, 0, 2});
    tbl.push_back('{3'd7, 8'd0, 8'd0, 8'd0, 0, 0, 1});
    tbl.push_back('{3'd2, 8'd5, 8'hF0, 8'h3C, 'h30, 0, 0});
    tbl.push_back('{3'd3, 8'd9, 8'hF0, 8'h3C, 'hFC, 0, 0});
    tbl.push_back('{3'd4, 8'd255, 8'hF0, 8'h3C, 'hCC, 0, 0});
`ifdef RPN_MUL_EN
    tbl.push_back('{3'd5, 8'd2, 8'd16, 8'd17, 16, 1, 0});
`else
    tbl.push_back('{3'd5, 8'd2, 8'd16, 8'd17, 0, 0, 2});
`endif
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    RESET_N  = 1'b0;
    op_valid = 1'b0;
    op_code  = 3'd0;
    sp_in    = 8'd0;
    repeat (2) @(negedge CLOCK_50);
    chk("rst.op_ready", 32'(op_ready), 1);
    chk("rst.flags", {busy, sp_wr, mem_wr, result_valid,
                      carry, err, err_code}, 0);
    chk("rst.buses", {result, sp_out, mem_addr, mem_wdata}, 0);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);

    foreach (tbl[i]) begin
      sp = tbl[i].sp;
      if (sp >= 2) begin
        mem[sp - 8'd2] = tbl[i].a;
        mem[sp - 8'd1] = tbl[i].b;
      end
      keep = mem[sp - 8'd1];
      apply($sformatf("tbl%0d", i), tbl[i].op, sp,
            tbl[i].r, tbl[i].c, tbl[i].ec);
      chk($sformatf("tbl%0d.tos_kept", i),
          32'(mem[sp - 8'd1]), 32'(keep));
    end

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) sp = 8'($urandom_range(0, 4));
      else sp = 8'($urandom_range(0, 255));
      if (sp >= 2) begin
        mem[sp - 8'd2] = 8'($urandom);
        mem[sp - 8'd1] = 8'($urandom);
        a = int'(mem[sp - 8'd2]);
        b = int'(mem[sp - 8'd1]);
      end else begin
        a = 0;
        b = 0;
      end
      model(op, int'(sp), a, b, r, c, ec);
      apply($sformatf("rnd%0d", i), op, sp, r, c, ec);
    end

    // reset lands in EXEC of an ADD: no write may reach the stack
    mem[0] = 8'd7;
    mem[1] = 8'd5;
    @(negedge CLOCK_50);
    op_valid = 1'b1;
    op_code  = 3'd0;
    sp_in    = 8'd2;
    @(posedge CLOCK_50);
    #1;
    op_valid = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    RESET_N = 1'b0;
    #1;
    chk("midrst.op_ready", 32'(op_ready), 1);
    chk("midrst.flags", {busy, sp_wr, mem_wr, result_valid,
                         carry, err, err_code}, 0);
    chk("midrst.buses", {result, sp_out, mem_addr, mem_wdata}, 0);
    hold_r = 0;
    hold_c = 0;
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    chk("midrst.ready_after", 32'(op_ready), 1);
    chk("midrst.mem0", 32'(mem[0]), 7);
    chk("midrst.mem1", 32'(mem[1]), 5);
    apply("post_rst_add", 3'd0, 8'd2, 12, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rpn_op_engine.md
# rpn_op_engine

Operator-execution stage of the RPN calculator, sitting directly downstream of the operand-push stage and sharing its stack RAM and stack pointer. On an operator request it pops the top two stack entries, computes NOS op TOS, writes the result back in place of NOS, and decrements the stack pointer. The push stage holds off while `busy` is high. `sp_out`/`sp_wr` feed the same load-enable stack-pointer register the push stage drives.

## Interface
- `DATA_W`, 8, stack word width
- `ADDR_W`, 8, stack address / pointer width

- `CLOCK_50`  in  1  sole clock, rising edge
- `RESET_N`  in  1  asynchronous, active-low reset
- `op_valid`  in  1  operator request
- `op_code`  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110/111 reserved
- `op_ready`  out  1  high only in IDLE
- `busy`  out  1  high in every state except IDLE
- `sp_in`  in  ADDR_W  current stack pointer (next free slot; TOS at `sp_in-1`)
- `sp_out`  out  ADDR_W  new stack pointer value
- `sp_wr`  out  1  one-cycle load strobe for the stack-pointer register
- `mem_addr`  out  ADDR_W  stack RAM address
- `mem_wr`  out  1  stack RAM write enable
- `mem_wdata`  out  DATA_W  stack RAM write data
- `mem_rdata`  in  DATA_W  stack RAM read data, valid one cycle after `mem_addr`
- `result`  out  DATA_W  last computed value, held
- `result_valid`  out  1  one-cycle pulse on completion
- `carry`  out  1  ADD carry-out / SUB borrow / MUL high-part-nonzero; 0 for logic ops
- `err`  out  1  sticky error flag
- `err_code`  out  2  00 none, 01 underflow, 10 bad opcode

## Operation
- Accept = `op_valid & op_ready`. At accept, latch `op_code` and `sp_in`. Clear `err`/`err_code`.
- Underflow check at accept: latched SP < 2 -> ERR, `err_code`=01. Underflow takes precedence over bad opcode.
- Reserved opcode (or 101 with MUL compiled out) -> ERR, `err_code`=10.
- FSM states and transitions:
  - IDLE -> RD_TOS on a valid accept.
  - IDLE -> ERR on an erroring accept.
  - ERR -> IDLE. In ERR: set `err`, no memory or SP activity.
  - RD_TOS: `mem_addr`=SP-1. Next state RD_NOS.
  - RD_NOS: `mem_addr`=SP-2; capture TOS from `mem_rdata`. Next state CAP_NOS.
  - CAP_NOS: capture NOS. Next state EXEC.
  - EXEC: compute into `result`/`carry`. Next state WRITE.
  - WRITE: `mem_addr`=SP-2, `mem_wdata`=result, `mem_wr`=1. Next state UPD_SP.
  - UPD_SP: `sp_out`=SP-1, `sp_wr`=1, `result_valid`=1. Next state IDLE.
- Arithmetic: all results modulo 2^DATA_W.
  - SUB = NOS−TOS; `carry`=1 on borrow.
  - MUL keeps the low DATA_W bits.
- `mem_wr`, `sp_wr`, `result_valid` are high only in their named states. `mem_addr` and `sp_out` are 0 when not driven.

## Timing
- Reset values of all outputs are 0, except `op_ready`=1. State is IDLE.
- Valid op accepted at cycle 0:
  - RD_TOS c1, RD_NOS c2, CAP_NOS c3, EXEC c4.
  - WRITE c5, UPD_SP c6 (`result_valid`, `sp_wr`).
  - `op_ready` high again at c7. Back-to-back throughput is one op per 7 cycles.
- Erroring op accepted at cycle 0: ERR at c1, `err` visible from c2, `op_ready` high at c2.
- `sp_in` and `op_code` changes after accept are ignored.
- `op_valid` while busy is ignored, not queued.
- Reset asserted mid-operation forces IDLE immediately. No write has occurred before WRITE, so the stack is unchanged unless reset lands after c5.

## Configuration
- `RPN_MUL_EN` defined: opcode 101 is MUL, using an integrated DATA_W×DATA_W multiplier; `carry` = (high half != 0).
- `RPN_MUL_EN` undefined: no multiplier is built, and 101 is treated as a reserved opcode (`err_code`=10).

## Test plan
- mem[0]=7, mem[1]=5, `sp_in`=2, ADD -> c5 write mem[0]=12, c6 `sp_out`=1, `result`=12, `carry`=0; mem[1] untouched.
- Same stack, SUB -> mem[0]=2, `carry`=0. Stack 5,7 (TOS 7), SUB -> mem[0]=254, `carry`=1.
- mem[0]=200, mem[1]=100, ADD -> mem[0]=44, `carry`=1. `sp_in`=1, ADD -> `err_code`=01, no `mem_wr`/`sp_wr`, `op_ready` back at c2.
- Opcode 110 -> `err_code`=10. With `RPN_MUL_EN`: 16×17 -> mem[0]=16, `carry`=1. Without it, 101 -> `err_code`=10.
- ADD accepted, `RESET_N` low at c4 -> all outputs reset, mem[0]/mem[1] unchanged, `op_ready`=1 after release.
